// File: rtl/isqrt_iter_fsm_if.sv
// Request/result bundle between a formula FSM (master) and the isqrt responder (slave).
// x_vld/x carries one radicand per strobe; y_vld/y returns the floor square root.
interface isqrt_iter_fsm_if;
  logic        x_vld;
  logic [31:0] x;
  logic        y_vld;
  logic [15:0] y;

  modport master (output x_vld, output x, input y_vld, input y);
  modport slave  (input x_vld, input x, output y_vld, output y);
endinterface

// File: rtl/isqrt_iter_fsm.sv
// Iterative floor(sqrt(x)) for 32-bit x, BITS_PER_CYCLE root bits per clock.
// Latency ITERS+1 cycles from x_vld to y_vld; one request in flight.
// No stall: x_vld taken in IDLE/DONE, silently dropped while BUSY.
module isqrt_iter_fsm #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  isqrt_iter_fsm_if.slave  bus
);

  localparam int ITERS = 16 / BITS_PER_CYCLE;
  localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   op;
  logic [17:0]   rem;
  logic [15:0]   root;
  logic [CW-1:0] cnt;
  logic          y_vld_r;
  logic [15:0]   y_r;

  logic [31:0]   op_nx;
  logic [17:0]   rem_nx;
  logic [15:0]   root_nx;
  logic [17:0]   rem_sh;
  logic [17:0]   trial;

  assign bus.y_vld = y_vld_r;
  assign bus.y     = y_r;

  // Unrolled digit-by-digit steps; remainder stays below 2*root+1 so 18 bits never overflow.
  always_comb begin
    op_nx   = op;
    rem_nx  = rem;
    root_nx = root;
    rem_sh  = '0;
    trial   = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      rem_sh = {rem_nx[15:0], op_nx[31:30]};
      op_nx  = {op_nx[29:0], 2'b00};
      trial  = {root_nx, 2'b01};
      if (rem_sh >= trial) begin
        rem_nx  = rem_sh - trial;
        root_nx = {root_nx[14:0], 1'b1};
      end else begin
        rem_nx  = rem_sh;
        root_nx = {root_nx[14:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op      <= '0;
      rem     <= '0;
      root    <= '0;
      cnt     <= '0;
      y_vld_r <= 1'b0;
      y_r     <= '0;
    end else begin
      y_vld_r <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.x_vld) begin
            op    <= bus.x;
            rem   <= '0;
            root  <= '0;
            cnt   <= CW'(ITERS - 1);
            state <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          op   <= op_nx;
          rem  <= rem_nx;
          root <= root_nx;
          if (cnt == '0) begin
            y_r     <= root_nx;
            y_vld_r <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_isqrt_iter_fsm.sv
// Scoreboard bench for isqrt_iter_fsm: driver queues expected root and due cycle,
// negedge monitor pops on y_vld and checks value, latency, single strobe and y hold.
module tb_isqrt_iter_fsm;

  localparam int BPC   = 1;
  localparam int ITERS = 16 / BPC;

  typedef struct {
    logic [15:0] y;
    int          due;
  } exp_t;

  logic clk;
  logic rst;
  isqrt_iter_fsm_if bus ();

  isqrt_iter_fsm #(.BITS_PER_CYCLE(BPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        q[$];
  int          checks;
  int          fails;
  int          cyc;
  logic [15:0] last_y;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] isqrt_ref(input logic [31:0] v);
    longint unsigned r, t;
    r = 0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= longint'(v)) r = t;
    end
    return 16'(r);
  endfunction

  // Monitor: decoupled from the driver, compares only against queued expectations.
  always @(negedge clk) begin
    if (rst) begin
      last_y = 16'h0;
    end else if (bus.y_vld) begin
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_y_vld: got y_vld=1 y=%0d at cycle %0d, required no strobe", bus.y, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bus.y !== e.y) begin
          fails++;
          $display("FAIL y_value: got %0d, required %0d (cycle %0d)", bus.y, e.y, cyc);
        end
        checks++;
        if (cyc != e.due) begin
          fails++;
          $display("FAIL latency: strobe at cycle %0d, required cycle %0d", cyc, e.due);
        end
      end
      last_y = bus.y;
    end else begin
      checks++;
      if (bus.y !== last_y) begin
        fails++;
        $display("FAIL y_hold: got %0d, required %0d (cycle %0d)", bus.y, last_y, cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [31:0] v, input logic [15:0] y_exp, input bit expect_result);
    exp_t e;
    bus.x_vld = 1'b1;
    bus.x     = v;
    if (expect_result) begin
      e.y   = y_exp;
      e.due = cyc + ITERS + 1;
      q.push_back(e);
    end
    step(1);
    bus.x_vld = 1'b0;
    bus.x     = 32'h0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      step(1);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL timeout: %0d results outstanding after %0d cycles, required 0", q.size(), n);
      q.delete();
    end
    step(2);
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (bus.y_vld !== 1'b0 || bus.y !== 16'h0) begin
      fails++;
      $display("FAIL %s: got y_vld=%0b y=%0d, required y_vld=0 y=0", name, bus.y_vld, bus.y);
    end
  endtask

  logic [31:0] vx [14] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd15, 32'd16, 32'd144, 32'd99,
                           32'd65535, 32'd65536, 32'd1000000, 32'hFFFE_0000, 32'hFFFE_0001,
                           32'hFFFF_FFFF};
  logic [15:0] vy [14] = '{16'd1, 16'd1, 16'd1, 16'd2, 16'd3, 16'd4, 16'd12, 16'd9,
                           16'd255, 16'd256, 16'd1000, 16'hFFFE, 16'hFFFF, 16'hFFFF};

  initial begin
    checks    = 0;
    fails     = 0;
    rst       = 1'b1;
    bus.x_vld = 1'b0;
    bus.x     = 32'h0;
    step(3);
    rst = 1'b0;
    step(1);
    check_idle_outputs("reset_state");

    issue(32'd0, 16'd0, 1'b1);
    wait_idle();

    foreach (vx[i]) begin
      issue(vx[i], vy[i], 1'b1);
      wait_idle();
    end

    // Back-to-back: second request lands in the DONE cycle of the first.
    issue(32'd144, 16'd12, 1'b1);
    step(ITERS);
    issue(32'd169, 16'd13, 1'b1);
    wait_idle();

    // Request while busy is dropped; the monitor flags any extra strobe.
    issue(32'd100, 16'd10, 1'b1);
    step(3);
    issue(32'd4, 16'd2, 1'b0);
    wait_idle();
    step(ITERS + 4);

    // Reset mid-operation aborts with no strobe.
    issue(32'd81, 16'd9, 1'b0);
    step(7);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_idle_outputs("reset_midop");
    step(ITERS + 8);
    issue(32'd81, 16'd9, 1'b1);
    wait_idle();

    for (int i = 0; i < 300; i++) begin
      logic [31:0] rx;
      rx = $urandom;
      if (i % 5 == 0) rx = rx >> $urandom_range(31, 1);
      issue(rx, isqrt_ref(rx), 1'b1);
      step(ITERS);
      if (i % 4 == 3) step(3);
    end
    wait_idle();

    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d outstanding, required 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
